gpr_sequencer: RTL



---
 rtl/gpr_sequencer.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/gpr_sequencer.sv
// Multi-cycle micro-sequencer: decodes 8-bit instructions, drives a 4 x DATA_WIDTH
// register file through two read ports and one write port, and holds the ALU flags.
module gpr_sequencer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [7:0]            instr_data,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  output logic [1:0]            read_address_1,
  output logic [1:0]            read_address_2,
  input  logic [DATA_WIDTH-1:0] read_data_1,
  input  logic [DATA_WIDTH-1:0] read_data_2,
  output logic [1:0]            write_address,
  output logic [DATA_WIDTH-1:0] write_data,
  output logic                  write_enable,
  output logic                  done,
  output logic                  zero_flag,
  output logic                  carry_flag,
  output logic [2:0]            debug_state
);

  // Handshake: a byte moves on a rising edge where instr_valid && instr_ready.
  // instr_ready is high only in IDLE (opcode byte) and IMM (immediate byte);
  // the source must hold instr_data stable until that edge.

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_EXEC  = 3'd2,
    S_IMM   = 3'd3,
    S_WRITE = 3'd4
  } state_t;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_AND  = 2'b10;
  localparam logic [1:0] OP_MOVI = 2'b11;

  state_t                  state;
  state_t                  next_state;
  logic [7:0]              instr_q;
  logic [DATA_WIDTH-1:0]   op_a;
  logic [DATA_WIDTH-1:0]   op_b;
  logic [DATA_WIDTH:0]     sum_ext;
  logic [DATA_WIDTH:0]     diff_ext;
  logic [DATA_WIDTH-1:0]   alu_result;
  logic                    alu_carry;
  logic                    accept;

  assign instr_ready  = (state == S_IDLE) || (state == S_IMM);
  assign accept       = instr_valid && instr_ready;
  assign write_enable = (state == S_WRITE);
  assign done         = (state == S_WRITE);
  assign debug_state  = state;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = S_IDLE;
    case (state)
      S_IDLE: begin
        next_state = S_IDLE;
        if (accept) next_state = (instr_data[7:6] == OP_MOVI) ? S_IMM : S_READ;
      end
      S_READ:  next_state = S_EXEC;
      S_EXEC:  next_state = S_WRITE;
      S_IMM:   next_state = accept ? S_WRITE : S_IMM;
      S_WRITE: next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Borrow for SUB is the top bit of the zero-extended difference (rs1 < rs2).
  assign sum_ext  = {1'b0, op_a} + {1'b0, op_b};
  assign diff_ext = {1'b0, op_a} - {1'b0, op_b};

  always_comb begin
    alu_result = '0;
    alu_carry  = 1'b0;
    case (instr_q[7:6])
      OP_ADD: begin
        alu_result = sum_ext[DATA_WIDTH-1:0];
        alu_carry  = sum_ext[DATA_WIDTH];
      end
      OP_SUB: begin
        alu_result = diff_ext[DATA_WIDTH-1:0];
        alu_carry  = diff_ext[DATA_WIDTH];
      end
      OP_AND: begin
        alu_result = op_a & op_b;
        alu_carry  = 1'b0;
      end
      default: begin
        alu_result = '0;
        alu_carry  = 1'b0;
      end
    endcase
  end

  // Read addresses load on the accept edge so they are already valid during READ;
  // write address/data load on the edge that enters WRITE and then hold.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      instr_q        <= '0;
      read_address_1 <= '0;
      read_address_2 <= '0;
      op_a           <= '0;
      op_b           <= '0;
      write_address  <= '0;
      write_data     <= '0;
      zero_flag      <= 1'b0;
      carry_flag     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            instr_q <= instr_data;
            if (instr_data[7:6] != OP_MOVI) begin
              read_address_1 <= instr_data[3:2];
              read_address_2 <= instr_data[1:0];
            end
          end
        end
        S_READ: begin
          op_a <= read_data_1;
          op_b <= read_data_2;
        end
        S_EXEC: begin
          write_address <= instr_q[5:4];
          write_data    <= alu_result;
          zero_flag     <= (alu_result == '0);
          carry_flag    <= alu_carry;
        end
        S_IMM: begin
          if (accept) begin
            write_address <= instr_q[5:4];
            write_data    <= DATA_WIDTH'(instr_data);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
